dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl_if.sv | 35 +++
 rtl/dmem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/response bus of the byte-addressed data memory
// err_o is present only when DMEM_MISALIGN_CHECK_EN is defined.
interface dmem_ctrl_if #(
  parameter int DW    = 32,
  parameter int ADDRW = 10
);
  logic             req_i;
  logic             we_i;
  logic [1:0]       size_i;
  logic             unsigned_i;
  logic [ADDRW-1:0] addr_i;
  logic [DW-1:0]    wdata_i;
  logic             ready_o;
  logic             rvalid_o;
  logic [DW-1:0]    rdata_o;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic             err_o;
`endif

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
`ifdef DMEM_MISALIGN_CHECK_EN
    input  err_o,
`endif
    input  ready_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
`ifdef DMEM_MISALIGN_CHECK_EN
    output err_o,
`endif
    output ready_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressed data memory with lane steering, load extension and post-reset clear sweep
// Optional misaligned-access error reporting: DMEM_MISALIGN_CHECK_EN.
module dmem_ctrl #(
  parameter int DW             = 32,
  parameter int MEM_SIZE_IN_KB = 1,
  parameter int READ_LAT       = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  dmem_ctrl_if.slave bus
);
  localparam int NB          = DW / 8;
  localparam int NO_OF_WORDS = MEM_SIZE_IN_KB * 1024 / NB;
  localparam int ADDRW       = $clog2(MEM_SIZE_IN_KB * 1024);
  localparam int OFFW        = $clog2(NB);
  localparam int IDXW        = ADDRW - OFFW;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam int PW = DW + 1;
`else
  localparam int PW = DW;
`endif

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] cnt_q;
  logic            clear_we;
  logic            ready;

  logic [DW-1:0]   mem [NO_OF_WORDS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_CLEAR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR && cnt_q == IDXW'(NO_OF_WORDS - 1)) state_d = S_READY;
  end

  always_comb begin
    clear_we = (state_q == S_CLEAR);
    ready    = (state_q == S_READY);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       cnt_q <= '0;
    else if (clear_we) cnt_q <= cnt_q + IDXW'(1);
  end

  assign bus.ready_o = ready;

  logic [IDXW-1:0] widx;
  logic [OFFW-1:0] off_raw, off_mask, off;
  logic [1:0]      size;
  logic            mis, acc, wr_en;
  logic [NB-1:0]   be;
  logic [DW-1:0]   wdata_sh;

  assign widx     = bus.addr_i[ADDRW-1:OFFW];
  assign off_raw  = bus.addr_i[OFFW-1:0];
  assign size     = (DW == 32 && bus.size_i == 2'd3) ? 2'd2 : bus.size_i;
  assign off_mask = OFFW'((4'd1 << size) - 4'd1);
`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis = |(off_raw & off_mask);
  assign off = off_raw;
`else
  // Without error reporting, misaligned offsets are silently aligned down.
  assign mis = 1'b0;
  assign off = off_raw & ~off_mask;
`endif

  assign acc      = bus.req_i && ready;
  assign wr_en    = acc && bus.we_i && !mis;
  assign wdata_sh = bus.wdata_i << {off, 3'b000};

  always_comb begin
    be = '0;
    for (int i = 0; i < NB; i++)
      if (i >= int'(off) && i < int'(off) + (1 << size)) be[i] = 1'b1;
  end

  // The sweep owns the write port until READY, so no request can collide with it.
  always_ff @(posedge clk_i) begin
    if (clear_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[widx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
    end
  end

  logic            s1_v_q, s1_we_q, s1_uns_q, s1_err_q;
  logic [1:0]      s1_size_q;
  logic [OFFW-1:0] s1_off_q;
  logic [DW-1:0]   s1_raw_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q    <= 1'b0;
      s1_we_q   <= 1'b0;
      s1_uns_q  <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_size_q <= '0;
      s1_off_q  <= '0;
      s1_raw_q  <= '0;
    end else begin
      s1_v_q <= acc;
      if (acc) begin
        s1_raw_q  <= mem[widx];
        s1_we_q   <= bus.we_i;
        s1_uns_q  <= bus.unsigned_i;
        s1_err_q  <= mis;
        s1_size_q <= size;
        s1_off_q  <= off;
      end
    end
  end

  logic [DW-1:0] sh, fmt;

  always_comb begin
    sh  = s1_raw_q >> {s1_off_q, 3'b000};
    fmt = '0;
    if (!s1_we_q && !s1_err_q) begin
      case (s1_size_q)
        2'd0: begin
          if (s1_uns_q) fmt = DW'(sh[7:0]);
          else          fmt = DW'($signed(sh[7:0]));
        end
        2'd1: begin
          if (s1_uns_q) fmt = DW'(sh[15:0]);
          else          fmt = DW'($signed(sh[15:0]));
        end
        2'd2: begin
          if (s1_uns_q) fmt = DW'(sh[31:0]);
          else          fmt = DW'($signed(sh[31:0]));
        end
        default: fmt = sh;
      endcase
    end
  end

  logic [PW-1:0] pay, out;
  logic          out_v;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign pay = {s1_err_q, fmt};
  assign {bus.err_o, bus.rdata_o} = out;
`else
  assign pay = fmt;
  assign bus.rdata_o = out;
`endif

  // Data registers load only with a valid entry so rdata_o holds between responses.
  generate
    if (READ_LAT == 1) begin : g_lat1
      assign out_v = s1_v_q;
      assign out   = pay;
    end else begin : g_latn
      logic          pv_q [READ_LAT-1];
      logic [PW-1:0] pd_q [READ_LAT-1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < READ_LAT - 1; i++) begin
            pv_q[i] <= 1'b0;
            pd_q[i] <= '0;
          end
        end else begin
          pv_q[0] <= s1_v_q;
          if (s1_v_q) pd_q[0] <= pay;
          for (int i = 1; i < READ_LAT - 1; i++) begin
            pv_q[i] <= pv_q[i-1];
            if (pv_q[i-1]) pd_q[i] <= pd_q[i-1];
          end
        end
      end

      assign out_v = pv_q[READ_LAT-2];
      assign out   = pd_q[READ_LAT-2];
    end
  endgenerate

  assign bus.rvalid_o = out_v;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed vector bench for dmem_ctrl (DW=32, 1 KiB, READ_LAT=3)
module tb_dmem_ctrl;
  localparam int LAT = 3;
  localparam int NW  = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.DW(32), .ADDRW(10)) bus ();

  dmem_ctrl #(.DW(32), .MEM_SIZE_IN_KB(1), .READ_LAT(LAT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  vec_t burst[$];

  function automatic vec_t mk(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                              input logic [9:0] a, input logic [31:0] wd, input logic [31:0] exp,
                              input logic err);
    vec_t v;
    v.name = nm; v.we = we; v.size = sz; v.uns = uns; v.addr = a;
    v.wdata = wd; v.exp_rdata = exp; v.exp_err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'd0; bus.unsigned_i = 1'b0;
    bus.addr_i = '0; bus.wdata_i = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.req_i = 1'b1; bus.we_i = v.we; bus.size_i = v.size; bus.unsigned_i = v.uns;
    bus.addr_i = v.addr; bus.wdata_i = v.wdata;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    @(negedge clk); drive(v);
    @(negedge clk); idle();
    cyc = 1;
    while (!bus.rvalid_o && cyc < LAT + 4) begin
      @(negedge clk);
      cyc++;
    end
    chk({v.name, "_lat"}, cyc, LAT);
    chk({v.name, "_rdata"}, bus.rdata_o, v.exp_rdata);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk({v.name, "_err"}, bus.err_o, v.exp_err);
`endif
  endtask

  task automatic run_burst(input string nm);
    logic        rv [16];
    logic [31:0] rd [16];
    int          n;
    n = burst.size();
    for (int c = 0; c < n + LAT + 2; c++) begin
      @(negedge clk);
      rv[c] = bus.rvalid_o;
      rd[c] = bus.rdata_o;
      if (c < n) drive(burst[c]);
      else       idle();
    end
    chk({nm, "_pre_idle"}, rv[LAT-1], 1'b0);
    for (int c = 0; c < n; c++) begin
      chk({nm, "_", burst[c].name, "_v"}, rv[c+LAT], 1'b1);
      chk({nm, "_", burst[c].name, "_d"}, rd[c+LAT], burst[c].exp_rdata);
    end
    chk({nm, "_post_idle"}, rv[n+LAT], 1'b0);
  endtask

  task automatic sweep(input string nm, inout logic seen);
    int cnt;
    cnt = 0;
    while (!bus.ready_o && cnt < 2000) begin
      if (bus.rvalid_o) seen = 1'b1;
      cnt++;
      @(negedge clk);
    end
    chk({nm, "_sweep_len"}, cnt, NW);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic seen;
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ready_o, 1'b0);
    chk("rst_rvalid", bus.rvalid_o, 1'b0);
    chk("rst_rdata", bus.rdata_o, 32'h0);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("rst_err", bus.err_o, 1'b0);
`endif
    seen = 1'b0;
    rst_n = 1'b1;
    sweep("init", seen);
    chk("init_no_rvalid", seen, 1'b0);

    vecs.push_back(mk("ld_w0",    0, 2, 0, 10'h000, 32'h0,        32'h00000000, 0));
    vecs.push_back(mk("ld_w1",    0, 2, 0, 10'h004, 32'h0,        32'h00000000, 0));
    vecs.push_back(mk("ld_wlast", 0, 2, 0, 10'h3FC, 32'h0,        32'h00000000, 0));
    vecs.push_back(mk("st_w10",   1, 2, 0, 10'h010, 32'hDEADBEEF, 32'h00000000, 0));
    vecs.push_back(mk("ld_bs13",  0, 0, 0, 10'h013, 32'h0,        32'hFFFFFFDE, 0));
    vecs.push_back(mk("ld_bu13",  0, 0, 1, 10'h013, 32'h0,        32'h000000DE, 0));
    vecs.push_back(mk("st_h22",   1, 1, 0, 10'h022, 32'h00008001, 32'h00000000, 0));
    vecs.push_back(mk("ld_w20",   0, 2, 0, 10'h020, 32'h0,        32'h80010000, 0));
    vecs.push_back(mk("ld_hs22",  0, 1, 0, 10'h022, 32'h0,        32'hFFFF8001, 0));
    vecs.push_back(mk("ld_hu12",  0, 1, 1, 10'h012, 32'h0,        32'h0000DEAD, 0));
    vecs.push_back(mk("ld_bs10",  0, 0, 0, 10'h010, 32'h0,        32'hFFFFFFEF, 0));
    vecs.push_back(mk("st_b21",   1, 0, 0, 10'h021, 32'h0000007F, 32'h00000000, 0));
    vecs.push_back(mk("ld_w20b",  0, 2, 0, 10'h020, 32'h0,        32'h80017F00, 0));
    vecs.push_back(mk("ld_bs21",  0, 0, 0, 10'h021, 32'h0,        32'h0000007F, 0));
    vecs.push_back(mk("st_b40",   1, 0, 0, 10'h040, 32'hFFFFFF55, 32'h00000000, 0));
    vecs.push_back(mk("ld_w40",   0, 2, 0, 10'h040, 32'h0,        32'h00000055, 0));
    vecs.push_back(mk("ld_sz3",   0, 3, 0, 10'h010, 32'h0,        32'hDEADBEEF, 0));
`ifdef DMEM_MISALIGN_CHECK_EN
    vecs.push_back(mk("st_mis31", 1, 2, 0, 10'h031, 32'h11223344, 32'h00000000, 1));
    vecs.push_back(mk("ld_w30",   0, 2, 0, 10'h030, 32'h0,        32'h00000000, 0));
    vecs.push_back(mk("ld_hmis",  0, 1, 0, 10'h013, 32'h0,        32'h00000000, 1));
`else
    vecs.push_back(mk("st_mis31", 1, 2, 0, 10'h031, 32'h11223344, 32'h00000000, 0));
    vecs.push_back(mk("ld_w30",   0, 2, 0, 10'h030, 32'h0,        32'h11223344, 0));
    vecs.push_back(mk("ld_hmis",  0, 1, 0, 10'h013, 32'h0,        32'hFFFFDEAD, 0));
`endif

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    burst.delete();
    burst.push_back(mk("a", 0, 2, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0));
    burst.push_back(mk("b", 0, 2, 0, 10'h020, 32'h0, 32'h80017F00, 0));
    burst.push_back(mk("c", 0, 2, 0, 10'h040, 32'h0, 32'h00000055, 0));
    burst.push_back(mk("d", 0, 0, 1, 10'h013, 32'h0, 32'h000000DE, 0));
    burst.push_back(mk("e", 0, 1, 0, 10'h022, 32'h0, 32'hFFFF8001, 0));
    run_burst("b2b");

    burst.delete();
    burst.push_back(mk("st", 1, 2, 0, 10'h050, 32'hCAFEF00D, 32'h00000000, 0));
    burst.push_back(mk("ld", 0, 2, 0, 10'h050, 32'h0,        32'hCAFEF00D, 0));
    burst.push_back(mk("sb", 1, 0, 0, 10'h051, 32'h000000AA, 32'h00000000, 0));
    burst.push_back(mk("lw", 0, 2, 0, 10'h050, 32'h0,        32'hCAFEAA0D, 0));
    burst.push_back(mk("lb", 0, 0, 0, 10'h051, 32'h0,        32'hFFFFFFAA, 0));
    run_burst("raw");

    seen = 1'b0;
    @(negedge clk); drive(mk("f0", 0, 2, 0, 10'h010, 32'h0, 32'h0, 0));
    @(negedge clk); drive(mk("f1", 0, 2, 0, 10'h020, 32'h0, 32'h0, 0));
    @(negedge clk); idle();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rvalid_o) seen = 1'b1;
    end
    chk("mid_rst_ready", bus.ready_o, 1'b0);
    rst_n = 1'b1;
    sweep("mid_rst", seen);
    chk("mid_rst_no_rvalid", seen, 1'b0);
    run_vec(mk("ld_after_rst", 0, 2, 0, 10'h010, 32'h0, 32'h00000000, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
